otter_muldiv: RTL and testbench
===============================

// Module: otter_muldiv
//
// PURPOSE
// Iterative RV32M multiply/divide unit for the OTTER MCU. Sits directly downstream of
// the ALU source muxes: consumes srcA/srcB alongside the ALU, computes one M-extension
// op over multiple cycles and stalls the pipeline through busy until the result is valid.
// Uses one shift-add multiplier and one restoring divider, both unsigned, with sign fix-up.
//
// PARAMETERS
// WIDTH  32  operand/result width; the counter sizes to $clog2(WIDTH)+1
//
// PORTS
// clk     in   1      system clock, rising edge
// rst     in   1      asynchronous, active-high reset
// start   in   1      launch op; sampled only in IDLE
// funct3  in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
// srcA    in   WIDTH  operand A / dividend (from ALU_muxA output)
// srcB    in   WIDTH  operand B / divisor
// busy    out  1      high from cycle after start accepted until done cycle (inclusive)
// done    out  1      one-cycle pulse; result valid this cycle and held afterwards
// result  out  WIDTH  result register; holds value until next accepted start
//
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, busy=0, done=0, result=0, counter=0, internals 0.
// - FSM: IDLE -start-> BUSY (normal) or IDLE -start-> DONE (special case); BUSY -cnt==0-> DONE;
//   DONE -> IDLE unconditionally. start is ignored in BUSY and DONE (no queueing).
// - On accept: latch funct3, operand magnitudes and result sign; signed operands per funct3:
//   MUL/MULH/DIV/REM both signed; MULHSU A signed, B unsigned; others unsigned.
// - BUSY: exactly WIDTH iterations, one per cycle (1 bit of multiplier / quotient per cycle).
// - Latency: normal op done=1 exactly WIDTH+1 cycles after the start-sampling edge (33 default);
//   special case done=1 one cycle after it. busy=1 on every cycle from accept+1 through done.
// - Multiply: 2*WIDTH-bit magnitude product, negate if sign set; MUL -> low WIDTH bits,
//   MULH/MULHSU/MULHU -> high WIDTH bits.
// - Divide: quotient sign = signA^signB, remainder sign = signA (RISC-V truncation).
// - Special cases (no iteration): divisor==0 -> DIV/DIVU all-ones, REM/REMU = srcA;
//   signed overflow (srcA=MIN_INT, srcB=-1, DIV/REM) -> DIV = MIN_INT, REM = 0.
// - Zero operands to MUL are not special-cased (full WIDTH iterations).
// - result updates only on the DONE transition; stable at all other times.
// - rst mid-op aborts immediately; no partial result appears; next start accepted normally.
//
// TESTING
// 1. MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done at cycle 33, busy high cycles 1-33.
// 2. MULH 0x80000000x0x80000000 -> 0x40000000; MULHU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFE;
//    MULHSU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFF.
// 3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// 4. DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, both with done one cycle after start.
// 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; latency 1.
// 6. start pulsed at cycle 10 of a busy op -> ignored, first result unchanged; rst at
//    cycle 15 -> busy=0, done=0, result=0 at once; fresh MUL 3x4 -> 12 after 33 cycles.

Source files
------------

// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add multiplier and one restoring divider
// sharing a hi/lo register pair, operating on magnitudes with a sign fix-up at the end.
module otter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]  b_q, b_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;

    logic              a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    add_sum, shifted, diff;
    logic [WIDTH-1:0]  hi_it, lo_it, quo, rem, final_res;
    logic [2*WIDTH-1:0] prod, prod_s;

    always_comb begin
        b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        a_signed = b_signed || (funct3 == 3'b010);
        a_neg    = a_signed & srcA[WIDTH-1];
        b_neg    = b_signed & srcB[WIDTH-1];
        a_mag    = a_neg ? -srcA : srcA;
        b_mag    = b_neg ? -srcB : srcB;
        div_zero = funct3[2] && (srcB == '0);
        div_ovf  = funct3[2] && !funct3[0] && (srcA == MinInt) && (srcB == '1);
    end

    // One iteration: multiply consumes lo[0] and shifts the product right; divide shifts
    // the dividend out of lo into the partial remainder in hi and shifts quotient bits in.
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (f3_q[2]) begin
            if (shifted >= {1'b0, b_q}) begin
                hi_it = diff[WIDTH-1:0];
                lo_it = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_it = shifted[WIDTH-1:0];
                lo_it = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_it = add_sum[WIDTH:1];
            lo_it = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = {hi_it, lo_it};
        prod_s = (sign_a_q ^ sign_b_q) ? -prod : prod;
        quo    = (sign_a_q ^ sign_b_q) ? -lo_it : lo_it;
        rem    = sign_a_q ? -hi_it : hi_it;
        unique case (f3_q)
            3'b000:                 final_res = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    f3_d     = funct3;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    b_d      = b_mag;
                    hi_d     = '0;
                    lo_d     = a_mag;
                    cnt_d    = CntW'(WIDTH - 1);
                    if (div_zero) begin
                        result_d = funct3[1] ? srcA : '1;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : MinInt;
                        state_d  = StDone;
                    end else begin
                        state_d  = StBusy;
                    end
                end
            end
            StBusy: begin
                hi_d  = hi_it;
                lo_d  = lo_it;
                cnt_d = cnt_q - 1'b1;
                // Last iteration lands directly in the result register.
                if (cnt_q == '0) begin
                    cnt_d    = '0;
                    result_d = final_res;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            f3_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_otter_muldiv.sv
// Bench for otter_muldiv: directed vector table, random ops against an arithmetic model,
// and hand-written sequences for ignored start and mid-op reset.
module tb_otter_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] MIN = 32'h8000_0000;

    otter_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'b000: p = sa * sb;
            3'b001: begin p = sa * sb; p = p >>> 32; end
            3'b010: begin p = sa * ub; p = p >>> 32; end
            3'b011: begin p = ua * ub; p = p >> 32; end
            3'b100: p = (b == 0) ? -1 : (a == MIN && b == '1) ? ua : sa / sb;
            3'b101: p = (b == 0) ? -1 : ua / ub;
            3'b110: p = (b == 0) ? ua : (a == MIN && b == '1) ? 0 : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MIN && b == '1))) return 1;
        return 33;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; funct3 = f; srcA = a; srcB = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        chk($sformatf("%s result", tag), result, exp);
        chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s busy-through-done", tag), {31'd0, busy_ok}, 32'd1);
        @(posedge clk); #1;
        chk($sformatf("%s busy after done", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s done pulse width", tag), {31'd0, done}, 32'd0);
        chk($sformatf("%s result hold", tag), result, exp);
    endtask

    initial begin
        vec_t vt[$];
        int cyc;
        logic [2:0]  f;
        logic [31:0] a, b;

        vt.push_back('{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vt.push_back('{3'b001, MIN,          MIN,           32'h4000_0000, 33});
        vt.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vt.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        vt.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33});
        vt.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33});
        vt.push_back('{3'b101, 32'd100,      32'd7,         32'd14,        33});
        vt.push_back('{3'b111, 32'd100,      32'd7,         32'd2,         33});
        vt.push_back('{3'b100, 32'd5,        32'd0,         32'hFFFF_FFFF, 1});
        vt.push_back('{3'b110, 32'd5,        32'd0,         32'd5,         1});
        vt.push_back('{3'b100, MIN,          32'hFFFF_FFFF, MIN,           1});
        vt.push_back('{3'b110, MIN,          32'hFFFF_FFFF, 32'd0,         1});
        vt.push_back('{3'b101, 32'd5,        32'd0,         32'hFFFF_FFFF, 1});
        vt.push_back('{3'b111, 32'd5,        32'd0,         32'd5,         1});
        vt.push_back('{3'b000, 32'd0,        32'd5,         32'd0,         33});
        vt.push_back('{3'b101, MIN,          32'hFFFF_FFFF, 32'd0,         33});

        #3;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i])
            do_op($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MIN; b = '1; end
                2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
                3: b = {28'hFFFF_FFF, 4'($urandom_range(0, 15))};
                default: ;
            endcase
            do_op($sformatf("rnd%0d f%0d", i, f), f, a, b, ref_op(f, a, b), ref_lat(f, a, b));
        end

        // start pulsed at cycle 10 of a busy op must be ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; srcA = 32'h0001_2345; srcB = 32'h0000_6789;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        repeat (8) begin @(posedge clk); #1; cyc++; end
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; srcA = 32'd99; srcB = 32'd0;
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        chk("ignored start result", result, ref_op(3'b000, 32'h0001_2345, 32'h0000_6789));
        chk("ignored start latency", 32'(cyc), 32'd33);
        @(posedge clk); #1;
        chk("ignored start not queued", {31'd0, busy}, 32'd0);

        // reset at cycle 15 of a busy op aborts at once
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; srcA = 32'd1000; srcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post-abort MUL", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
